// File: rtl/divider_4bit_pkg.sv
// divider_4bit_pkg: shared state type and sizing constants for the restoring divider.
package divider_4bit_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DEF_WIDTH = 4;
   localparam int CNT_W = $clog2(DEF_WIDTH);
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction
endpackage

// File: rtl/divider_4bit_sub_stage.sv
// sub_stage: combinational ripple subtract stage returning difference and borrow-out.
module sub_stage #(
   parameter int W = 5
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   output logic [W-1:0] d_o,
   output logic         bo_o
);
   assign {bo_o, d_o} = {1'b0, x_i} - {1'b0, y_i};
endmodule

// File: rtl/divider_4bit.sv
// divider_4bit: sequential restoring divider, one quotient bit per cycle, MSB first.
module divider_4bit
   import divider_4bit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div0
);
   localparam int CW = cnt_w(WIDTH);
   state_t           state_q;
   logic [WIDTH:0]   p_q, t, d, p_d;
   logic [WIDTH-1:0] dvd_q, dvs_q, dvd_d, q_q, r_q;
   logic [CW-1:0]    cnt_q;
   logic             bo, busy_q, done_q, div0_q;
   // The shift drops p's top bit, which is always zero since p stays below the divisor.
   assign t     = (p_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
   assign p_d   = bo ? t : d;
   assign dvd_d = {dvd_q[WIDTH-2:0], ~bo};
   sub_stage #(.W(WIDTH + 1)) u_sub (
      .x_i  (t),
      .y_i  ({1'b0, dvs_q}),
      .d_o  (d),
      .bo_o (bo)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q     <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else if (state_q == RUN) begin
         p_q   <= p_d;
         dvd_q <= dvd_d;
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == '0) begin
            state_q <= DONE;
            q_q     <= dvd_d;
            r_q     <= p_d[WIDTH-1:0];
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
         end
      end else if (start && b != '0) begin
         state_q <= RUN;
         dvd_q   <= a;
         dvs_q   <= b;
         p_q     <= '0;
         cnt_q   <= CW'(WIDTH - 1);
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else if (start) begin
         state_q <= DONE;
         q_q     <= '1;
         r_q     <= a;
         div0_q  <= 1'b1;
         done_q  <= 1'b1;
      end else begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end
   end
   assign q    = q_q;
   assign r    = r_q;
   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;
endmodule
